// File: rtl/ram_result_scanner_if.sv
// Bundle between the result-RAM scanner and its surroundings: scan request/window in,
// RAM read port and window statistics out.
interface ram_result_scanner_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 9,
  parameter int SUM_W  = 13
);
  logic              start_i;
  logic [ADDR_W-1:0] first_addr_i;
  logic [ADDR_W-1:0] last_addr_i;
  logic [DATA_W-1:0] ram_data_i;
  logic [ADDR_W-1:0] scan_addr_o;
  logic              scan_busy_o;
  logic              done_o;
  logic [SUM_W-1:0]  sum_o;
  logic [DATA_W-1:0] max_o;
  logic [DATA_W-1:0] min_o;
  logic [ADDR_W:0]   neg_count_o;

  modport slave (
    input  start_i, first_addr_i, last_addr_i, ram_data_i,
    output scan_addr_o, scan_busy_o, done_o, sum_o, max_o, min_o, neg_count_o
  );

  modport master (
    output start_i, first_addr_i, last_addr_i, ram_data_i,
    input  scan_addr_o, scan_busy_o, done_o, sum_o, max_o, min_o, neg_count_o
  );
endinterface

// File: rtl/ram_result_scanner.sv
// Walks an address window of the sign-magnitude result RAM and reports the
// two's-complement sum, max, min and negative count over that window.
module ram_result_scanner #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 9,
  parameter int SUM_W  = 13
) (
  input logic                 clk,
  input logic                 rst_n,
  ram_result_scanner_if.slave bus
);
  localparam int MAG_W = DATA_W - 1;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, READ, DONE} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         scan_addr_q, scan_addr_d;
  logic [ADDR_W-1:0]         last_q, last_d;
  logic                      first_q, first_d;
  logic signed [SUM_W-1:0]   sum_acc_q, sum_acc_d;
  logic signed [DATA_W-1:0]  max_acc_q, max_acc_d;
  logic signed [DATA_W-1:0]  min_acc_q, min_acc_d;
  logic [CNT_W-1:0]          neg_acc_q, neg_acc_d;
  logic signed [SUM_W-1:0]   sum_out_q, sum_out_d;
  logic signed [DATA_W-1:0]  max_out_q, max_out_d;
  logic signed [DATA_W-1:0]  min_out_q, min_out_d;
  logic [CNT_W-1:0]          neg_out_q, neg_out_d;

  logic                      sample_sign;
  logic [MAG_W-1:0]          sample_mag;
  logic signed [DATA_W-1:0]  sample_val;
  logic signed [SUM_W-1:0]   sample_ext;
  logic                      sample_neg;

  // Negative zero negates to zero, so it never sets the sign bit of sample_val.
  assign sample_sign = bus.ram_data_i[DATA_W-1];
  assign sample_mag  = bus.ram_data_i[MAG_W-1:0];
  assign sample_val  = sample_sign ? -$signed({1'b0, sample_mag}) : $signed({1'b0, sample_mag});
  assign sample_neg  = sample_val[DATA_W-1];
  assign sample_ext  = {{(SUM_W-DATA_W){sample_val[DATA_W-1]}}, sample_val};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      scan_addr_q <= '0;
      last_q      <= '0;
      first_q     <= 1'b0;
      sum_acc_q   <= '0;
      max_acc_q   <= '0;
      min_acc_q   <= '0;
      neg_acc_q   <= '0;
      sum_out_q   <= '0;
      max_out_q   <= '0;
      min_out_q   <= '0;
      neg_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      scan_addr_q <= scan_addr_d;
      last_q      <= last_d;
      first_q     <= first_d;
      sum_acc_q   <= sum_acc_d;
      max_acc_q   <= max_acc_d;
      min_acc_q   <= min_acc_d;
      neg_acc_q   <= neg_acc_d;
      sum_out_q   <= sum_out_d;
      max_out_q   <= max_out_d;
      min_out_q   <= min_out_d;
      neg_out_q   <= neg_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    scan_addr_d = scan_addr_q;
    last_d      = last_q;
    first_d     = first_q;
    sum_acc_d   = sum_acc_q;
    max_acc_d   = max_acc_q;
    min_acc_d   = min_acc_q;
    neg_acc_d   = neg_acc_q;
    sum_out_d   = sum_out_q;
    max_out_d   = max_out_q;
    min_out_d   = min_out_q;
    neg_out_d   = neg_out_q;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          last_d      = bus.last_addr_i;
          scan_addr_d = bus.first_addr_i;
          sum_acc_d   = '0;
          max_acc_d   = '0;
          min_acc_d   = '0;
          neg_acc_d   = '0;
          first_d     = 1'b1;
          state_d     = READ;
        end
      end
      READ: begin
        sum_acc_d = sum_acc_q + sample_ext;
        if (first_q || (sample_val > max_acc_q)) max_acc_d = sample_val;
        if (first_q || (sample_val < min_acc_q)) min_acc_d = sample_val;
        if (sample_neg) neg_acc_d = neg_acc_q + CNT_W'(1);
        first_d = 1'b0;
        if (scan_addr_q == last_q) begin
          // Load results on the edge into DONE so they are valid while done is high.
          sum_out_d = sum_acc_d;
          max_out_d = max_acc_d;
          min_out_d = min_acc_d;
          neg_out_d = neg_acc_d;
          state_d   = DONE;
        end else begin
          scan_addr_d = scan_addr_q + ADDR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.scan_addr_o = scan_addr_q;
  assign bus.scan_busy_o = (state_q == READ);
  assign bus.done_o      = (state_q == DONE);
  assign bus.sum_o       = sum_out_q;
  assign bus.max_o       = max_out_q;
  assign bus.min_o       = min_out_q;
  assign bus.neg_count_o = neg_out_q;
endmodule

// File: tb/tb_ram_result_scanner.sv
// Scoreboard bench for ram_result_scanner: stimulus pushes expected results and
// address visits computed from the window rules; a negedge monitor pops and compares.
module tb_ram_result_scanner;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 9;
  localparam int SUM_W  = 13;
  localparam int DEPTH  = 16;

  typedef struct {
    int sum;
    int mx;
    int mn;
    int neg;
    int done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_result_scanner_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SUM_W(SUM_W)) bus ();

  ram_result_scanner #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SUM_W(SUM_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  assign bus.ram_data_i = mem[bus.scan_addr_o];

  exp_t exp_q[$];
  int   addr_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   held_sum = 0, held_max = 0, held_min = 0, held_neg = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int s_sum();
    return int'($signed(bus.sum_o));
  endfunction
  function automatic int s_max();
    return int'($signed(bus.max_o));
  endfunction
  function automatic int s_min();
    return int'($signed(bus.min_o));
  endfunction

  // Reference: window length ((last-first) mod 16)+1, sign-magnitude to integer.
  task automatic push_model(int first, int last, int done_cyc);
    exp_t e;
    int n, a, v;
    n = ((last - first) & (DEPTH - 1)) + 1;
    e.sum = 0; e.neg = 0; e.mx = 0; e.mn = 0;
    e.done_cyc = done_cyc;
    for (int i = 0; i < n; i++) begin
      a = (first + i) & (DEPTH - 1);
      addr_q.push_back(a);
      v = int'(mem[a][DATA_W-2:0]);
      if (mem[a][DATA_W-1]) v = -v;
      e.sum += v;
      if (i == 0 || v > e.mx) e.mx = v;
      if (i == 0 || v < e.mn) e.mn = v;
      if (v < 0) e.neg++;
    end
    exp_q.push_back(e);
  endtask

  function automatic int win_len(int first, int last);
    return ((last - first) & (DEPTH - 1)) + 1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      held_sum = 0; held_max = 0; held_min = 0; held_neg = 0;
    end else begin
      if (bus.scan_busy_o) begin
        if (addr_q.size() == 0) check("busy_without_scan", 1, 0);
        else check("scan_addr", int'(bus.scan_addr_o), addr_q.pop_front());
      end
      if (bus.done_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_cycle", cyc, mon_e.done_cyc);
          check("sum", s_sum(), mon_e.sum);
          check("max", s_max(), mon_e.mx);
          check("min", s_min(), mon_e.mn);
          check("neg_count", int'(bus.neg_count_o), mon_e.neg);
          held_sum = mon_e.sum; held_max = mon_e.mx;
          held_min = mon_e.mn;  held_neg = mon_e.neg;
        end
      end else begin
        check("hold_sum", s_sum(), held_sum);
        check("hold_max", s_max(), held_max);
        check("hold_min", s_min(), held_min);
        check("hold_neg", int'(bus.neg_count_o), held_neg);
      end
    end
  end

  // Call at a negedge while the DUT is idle.
  task automatic issue(int first, int last, bit hold);
    bus.first_addr_i = ADDR_W'(first);
    bus.last_addr_i  = ADDR_W'(last);
    bus.start_i      = 1'b1;
    push_model(first, last, cyc + 1 + win_len(first, last));
    if (hold) begin
      // Held start re-launches in the IDLE cycle after DONE.
      push_model(first, last, cyc + 1 + win_len(first, last) + 2 + win_len(first, last));
    end else begin
      @(negedge clk);
      bus.start_i      = 1'b0;
      bus.first_addr_i = ADDR_W'($urandom);
      bus.last_addr_i  = ADDR_W'($urandom);
    end
  endtask

  task automatic wait_drain(int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    bus.start_i = 1'b0;
    if (exp_q.size() != 0) begin
      check("done_timeout", int'(exp_q.size()), 0);
      exp_q.delete();
      addr_q.delete();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DATA_W'($urandom_range(0, 511));
      if ($urandom_range(0, 7) == 0) mem[i] = 9'h100;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bus.start_i = 1'b0;
    bus.first_addr_i = '0;
    bus.last_addr_i = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.scan_busy_o), 0);
    check("rst_done", int'(bus.done_o), 0);
    check("rst_addr", int'(bus.scan_addr_o), 0);
    check("rst_sum", s_sum(), 0);
    check("rst_neg", int'(bus.neg_count_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single entry, negative.
    mem[4] = 9'b1_0000_1010;
    issue(4, 4, 1'b0);
    wait_drain(40);
    check("t1_sum", s_sum(), -10);
    check("t1_max", s_max(), -10);
    check("t1_min", s_min(), -10);
    check("t1_neg", int'(bus.neg_count_o), 1);

    // Full sweep at maximum positive magnitude.
    for (int i = 0; i < DEPTH; i++) mem[i] = 9'b0_1111_1111;
    issue(0, 15, 1'b0);
    wait_drain(40);
    check("t2_sum", s_sum(), 4080);
    check("t2_max", s_max(), 255);
    check("t2_min", s_min(), 255);
    check("t2_neg", int'(bus.neg_count_o), 0);

    // Wrapping window with negative zero, start held to force a back-to-back rescan.
    mem[14] = 9'd3;
    mem[15] = 9'b1_0000_0101;
    mem[0]  = 9'd7;
    mem[1]  = 9'b1_0000_0000;
    issue(14, 1, 1'b1);
    wait_drain(60);
    check("t3_sum", s_sum(), 5);
    check("t3_max", s_max(), 7);
    check("t3_min", s_min(), -5);
    check("t3_neg", int'(bus.neg_count_o), 1);

    // Reset in the middle of a full sweep.
    issue(0, 15, 1'b0);
    n = 0;
    while (!(bus.scan_busy_o && bus.scan_addr_o == 6) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_addr6", int'(bus.scan_addr_o), 6);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(bus.scan_busy_o), 0);
    check("mid_rst_done", int'(bus.done_o), 0);
    check("mid_rst_addr", int'(bus.scan_addr_o), 0);
    check("mid_rst_sum", s_sum(), 0);
    check("mid_rst_max", s_max(), 0);
    check("mid_rst_min", s_min(), 0);
    check("mid_rst_neg", int'(bus.neg_count_o), 0);
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    mem[4] = 9'b1_0000_1010;
    issue(4, 4, 1'b0);
    wait_drain(40);
    check("t5_sum", s_sum(), -10);
    check("t5_neg", int'(bus.neg_count_o), 1);

    // Mixed signs at the magnitude extremes.
    mem[0] = 9'b1_1111_1111;
    mem[1] = 9'b0_1111_1111;
    mem[2] = 9'b1_0000_0001;
    issue(0, 2, 1'b0);
    wait_drain(40);
    check("t6_sum", s_sum(), -1);
    check("t6_max", s_max(), 255);
    check("t6_min", s_min(), -255);
    check("t6_neg", int'(bus.neg_count_o), 2);

    // Randomized windows and contents.
    for (int k = 0; k < 40; k++) begin
      fill_random();
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);
      wait_drain(60);
    end

    repeat (3) @(negedge clk);
    check("leftover_addrs", int'(addr_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
